// File: rtl/alu_bist.sv
// alu_bist: built-in self-test sequencer for a combinational ALU.
// It walks every operation select with pseudo-random operand pairs from two
// LFSRs and folds each ALU response into a 32-bit MISR signature. At the end
// of the run it compares the signature with a golden value.
// Optional feature macro: ALU_BIST_FLAGS_EN. When it is defined, the ALU flags
// (zero, overflow, carry-out) are folded into MISR bits [2:0].
module alu_bist #(
  parameter int          WIDTH   = 32,
  parameter int          VECTORS = 16,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      expected_sig,
  output logic [2:0]       alu_S,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      signature
);

  // A single vector per select still needs a one-bit counter.
  localparam int          VW       = (VECTORS > 1) ? $clog2(VECTORS) : 1;
  localparam logic [VW-1:0] VEC_LAST = VW'(VECTORS - 1);
  localparam logic [31:0] POLY     = 32'h0040_0007;
  localparam logic [2:0]  OP_LAST  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Galois-style shift shared by both operand LFSRs and the MISR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0000_0000);
  endfunction

  // One MISR compression step: shift with feedback, then inject the response.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    misr_step = lfsr_step(s) ^ d;
  endfunction

  state_t            state_r, state_s;
  logic [31:0]       lfsr_a_r, lfsr_a_s;
  logic [31:0]       lfsr_b_r, lfsr_b_s;
  logic [2:0]        op_r, op_s;
  logic [VW-1:0]     vec_r, vec_s;
  logic [31:0]       sig_r, sig_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [31:0]       data_s;
  logic [31:0]       misr_s;
  logic              last_s;

`ifndef ALU_BIST_FLAGS_EN
  // Flags do not contribute to the signature in this build.
  logic unused_flags_s;
  assign unused_flags_s = alu_zero ^ alu_overflow ^ alu_cout;
`endif

  // Build the MISR input word from the ALU response.
  always_comb begin
    data_s = 32'h0000_0000;
    data_s[WIDTH-1:0] = alu_out;
`ifdef ALU_BIST_FLAGS_EN
    data_s[2:0] = data_s[2:0] ^ {alu_zero, alu_overflow, alu_cout};
`endif
  end

  assign misr_s = misr_step(sig_r, data_s);
  assign last_s = (op_r == OP_LAST) && (vec_r == VEC_LAST);

  // Next-state and next-value logic for the sequencer.
  always_comb begin
    state_s  = state_r;
    lfsr_a_s = lfsr_a_r;
    lfsr_b_s = lfsr_b_r;
    op_s     = op_r;
    vec_s    = vec_r;
    sig_s    = sig_r;
    busy_s   = busy_r;
    done_s   = done_r;
    pass_s   = pass_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s  = RUN;
          lfsr_a_s = SEED;
          lfsr_b_s = ~SEED;
          op_s     = 3'd0;
          vec_s    = '0;
          sig_s    = 32'h0000_0000;
          busy_s   = 1'b1;
          done_s   = 1'b0;
          pass_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        // Every RUN edge absorbs the response to the vector currently driven.
        sig_s = misr_s;
        if (last_s) begin
          // Operands and select hold their final values in DONE.
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (misr_s == expected_sig);
        end else begin
          lfsr_a_s = lfsr_step(lfsr_a_r);
          lfsr_b_s = lfsr_step(lfsr_b_r);
          if (vec_r == VEC_LAST) begin
            vec_s = '0;
            op_s  = op_r + 3'd1;
          end else begin
            vec_s = vec_r + VW'(1);
            op_s  = op_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run and zeroes all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      lfsr_a_r <= 32'h0000_0000;
      lfsr_b_r <= 32'h0000_0000;
      op_r     <= 3'd0;
      vec_r    <= '0;
      sig_r    <= 32'h0000_0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      lfsr_a_r <= lfsr_a_s;
      lfsr_b_r <= lfsr_b_s;
      op_r     <= op_s;
      vec_r    <= vec_s;
      sig_r    <= sig_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      pass_r   <= pass_s;
    end
  end

  assign alu_S     = op_r;
  assign alu_A     = lfsr_a_r[WIDTH-1:0];
  assign alu_B     = lfsr_b_r[WIDTH-1:0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = sig_r;

endmodule

// File: tb/tb_alu_bist.sv
// Directed testbench for alu_bist with a behavioural ALU and reference MISR.
module tb_alu_bist;
  localparam int          WIDTH   = 32;
  localparam int          VECTORS = 2;
  localparam int          NV      = 8 * VECTORS;
  localparam logic [31:0] SEED    = 32'h0000_0001;
  localparam logic [31:0] POLY    = 32'h0040_0007;

  logic        clk = 1'b0;
  logic        reset, start, zforce;
  logic [31:0] expected_sig;
  logic [2:0]  alu_S;
  logic [31:0] alu_A, alu_B, alu_out;
  logic        alu_zero, alu_overflow, alu_cout;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [34:0] resp;

  int errors = 0;
  int checks = 0;
  logic [31:0] ma [NV];
  logic [31:0] mb [NV];
  logic [31:0] base_sig, forced_sig;

  alu_bist #(.WIDTH(WIDTH), .VECTORS(VECTORS), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .expected_sig(expected_sig),
    .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_cout(alu_cout),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {zero, overflow, cout, result}.
  function automatic logic [34:0] alu_model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic ov, co;
    w = 33'h0; r = 32'h0; ov = 1'b0; co = 1'b0;
    case (s)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; co = w[32]; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; co = w[32]; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = {31'h0, ($signed(a) < $signed(b))};
      3'd6: r = a << b[4:0];
      3'd7: r = ~(a | b);
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), ov, co, r};
  endfunction

  // Combinational ALU beside the DUT, with an optional forced zero flag.
  always_comb begin
    resp         = alu_model(alu_S, alu_A, alu_B);
    alu_out      = resp[31:0];
    alu_cout     = resp[32];
    alu_overflow = resp[33];
    alu_zero     = resp[34] | zforce;
  end

  function automatic logic [31:0] step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
  endfunction

  // Reference signature; fv selects a vector whose zero flag is forced high.
  function automatic logic [31:0] model_sig(input int fv);
    logic [31:0] s, d;
    logic [34:0] r;
    logic z;
    s = 32'h0;
    for (int k = 0; k < NV; k++) begin
      r = alu_model(3'(k / VECTORS), ma[k], mb[k]);
      z = r[34] | (k == fv);
      d = r[31:0];
`ifdef ALU_BIST_FLAGS_EN
      d[2:0] = d[2:0] ^ {z, r[33], r[32]};
`endif
      s = step(s) ^ d;
    end
    return s;
  endfunction

  task automatic build_model();
    logic [31:0] a, b;
    a = SEED; b = ~SEED;
    for (int k = 0; k < NV; k++) begin
      ma[k] = a; mb[k] = b;
      a = step(a); b = step(b);
    end
    base_sig   = model_sig(-1);
    forced_sig = model_sig(5);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Full run: checks every driven vector and returns cycles until done.
  task automatic do_run(input logic [31:0] exp, input int fv, input bit spam, output int cyc);
    expected_sig = exp;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || alu_A !== ma[0] || alu_B !== mb[0]) begin
      errors++;
      $display("FAIL run_start: busy=%b done=%b A=%h B=%h, required busy=1 done=0 A=%h B=%h", busy, done, alu_A, alu_B, ma[0], mb[0]);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc < NV) begin
        checks++;
        if (alu_S !== 3'(cyc / VECTORS) || alu_A !== ma[cyc] || alu_B !== mb[cyc] || busy !== 1'b1) begin
          errors++;
          $display("FAIL vector_seq[%0d]: S=%0d A=%h B=%h busy=%b, required S=%0d A=%h B=%h busy=1", cyc, alu_S, alu_A, alu_B, busy, cyc / VECTORS, ma[cyc], mb[cyc]);
        end
      end
      zforce = (cyc == fv);
      start  = spam && (cyc > 0) && (cyc < NV - 1) && (cyc % 3 == 1);
      @(posedge clk); #1;
      cyc++;
    end
    zforce = 1'b0;
    start  = 1'b0;
    checks++;
    if (cyc != NV) begin
      errors++;
      $display("FAIL run_length: done after %0d cycles, required %0d", cyc, NV);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; zforce = 1'b0; expected_sig = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, alu_S, alu_A, alu_B, signature} !== 102'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b S=%0d A=%h B=%h sig=%h, required all 0", busy, done, pass, alu_S, alu_A, alu_B, signature);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_first_vectors();
    int n;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || alu_S !== 3'd0 || alu_A !== 32'h0000_0001 || alu_B !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL first_vector: busy=%b S=%0d A=%h B=%h, required busy=1 S=0 A=00000001 B=fffffffe", busy, alu_S, alu_A, alu_B);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_A !== 32'h0000_0002 || alu_B !== 32'hFFBF_FFFB) begin
      errors++;
      $display("FAIL second_vector: A=%h B=%h, required A=00000002 B=ffbffffb", alu_A, alu_B);
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL first_run_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_pass_run();
    int cyc;
    do_run(base_sig, -1, 1'b0, cyc);
    checks++;
    if (pass !== 1'b1 || signature !== base_sig) begin
      errors++;
      $display("FAIL pass_run: pass=%b sig=%h, required pass=1 sig=%h", pass, signature, base_sig);
    end
  endtask

  task automatic test_fail_run();
    int cyc;
    do_run(base_sig ^ 32'h0000_0001, -1, 1'b0, cyc);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || signature !== base_sig) begin
      errors++;
      $display("FAIL mismatch_run: done=%b pass=%b sig=%h, required done=1 pass=0 sig=%h", done, pass, signature, base_sig);
    end
  endtask

  task automatic test_hold();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b0 || signature !== base_sig || alu_S !== 3'd7 || alu_A !== ma[NV-1] || alu_B !== mb[NV-1]) begin
      errors++;
      $display("FAIL done_hold: done=%b busy=%b pass=%b sig=%h S=%0d A=%h, required done=1 busy=0 pass=0 sig=%h S=7 A=%h", done, busy, pass, signature, alu_S, alu_A, base_sig, ma[NV-1]);
    end
  endtask

  task automatic test_start_in_run();
    int cyc;
    do_run(base_sig, -1, 1'b1, cyc);
    checks++;
    if (pass !== 1'b1 || signature !== base_sig) begin
      errors++;
      $display("FAIL start_ignored: pass=%b sig=%h, required pass=1 sig=%h", pass, signature, base_sig);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    expected_sig = base_sig;
    pulse_start();
    repeat (5) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, alu_S, alu_A, alu_B, signature} !== 102'h0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b pass=%b S=%0d A=%h B=%h sig=%h, required all 0", busy, done, pass, alu_S, alu_A, alu_B, signature);
    end
    @(negedge clk); reset = 1'b0;
    do_run(base_sig, -1, 1'b0, cyc);
    checks++;
    if (pass !== 1'b1 || signature !== base_sig) begin
      errors++;
      $display("FAIL rerun_after_reset: pass=%b sig=%h, required pass=1 sig=%h", pass, signature, base_sig);
    end
  endtask

  task automatic test_flag_fold();
    int cyc;
    logic [31:0] want;
`ifdef ALU_BIST_FLAGS_EN
    want = forced_sig;
`else
    want = base_sig;
`endif
    do_run(want, 5, 1'b0, cyc);
    checks++;
    if (signature !== want || pass !== 1'b1) begin
      errors++;
      $display("FAIL flag_fold: sig=%h pass=%b, required sig=%h pass=1", signature, pass, want);
    end
`ifdef ALU_BIST_FLAGS_EN
    checks++;
    if (signature === base_sig) begin
      errors++;
      $display("FAIL flag_sensitivity: sig=%h, required value different from baseline %h", signature, base_sig);
    end
`endif
  endtask

  initial begin
    build_model();
    test_reset();
    test_first_vectors();
    test_pass_run();
    test_fail_run();
    test_hold();
    test_start_in_run();
    test_reset_midrun();
    test_flag_fold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer for the ALU. On a start pulse it drives pseudo-random operand pairs through every ALU operation select, compresses the ALU's result and flag outputs into a 32-bit signature, and compares it with an expected value. It sits beside the ALU and drives the ALU's S/A/B inputs. It observes the ALU's out/Zero/Overflow/Cout, so the same checking a testbench does can run in hardware.

## Interface
- WIDTH, 32, ALU datapath width; legal range 8..32.
- VECTORS, 16, vectors applied per operation select; legal range 1..256.
- SEED, 32'h0000_0001, nonzero seed for the operand-A LFSR; operand-B LFSR is seeded with ~SEED.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- expected_sig  in  32  golden signature, sampled on the final absorb edge.
- alu_S  out  3  operation select to ALU.
- alu_A  out  WIDTH  operand A to ALU.
- alu_B  out  WIDTH  operand B to ALU.
- alu_out  in  WIDTH  ALU result.
- alu_zero, alu_overflow, alu_cout  in  1 each  ALU flags.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- pass  out  1  signature matched; valid while done=1.
- signature  out  32  current MISR value.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE with every output 0.
- IDLE/DONE with start=1: LFSR_A←SEED, LFSR_B←~SEED, op←0, vec←0, sig←0, pass←0, state←RUN.
- Start is ignored in RUN.
- LFSR step, both LFSRs: next = {l[30:0],1'b0} ^ (l[31] ? 32'h0040_0007 : 0).
- alu_A = LFSR_A[WIDTH-1:0] and alu_B = LFSR_B[WIDTH-1:0], both registered.
- RUN, each edge: absorb the current ALU response into the MISR, then advance to the next vector.
  - vec increments; on vec=VECTORS-1, vec←0 and op (alu_S) increments.
  - Order: S=0 with VECTORS vectors, then S=1, … through S=7. Total 8·VECTORS vectors.
- MISR: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 0) ^ D.
  - D = zero-extended alu_out XOR {29'b0, alu_zero, alu_overflow, alu_cout} (flag term per Configuration).
- Final absorb edge (vector 8·VECTORS-1):
  - state←DONE, done←1, busy←0.
  - pass←(sig_next == expected_sig).
  - alu_S/A/B hold their last values.
- DONE holds signature, pass, and done until start or reset. Start in DONE restarts immediately, with no IDLE visit.
- Reset mid-run aborts asynchronously: all outputs 0, state IDLE, no partial pass.

## Timing
- Start sampled at edge E0. From E0: busy=1, alu_S=0, alu_A=SEED[WIDTH-1:0], alu_B=~SEED[WIDTH-1:0].
- Vector k is driven during the cycle after edge E0+k and absorbed at edge E0+k+1.
- ALU is combinational; no extra latency is inserted.
- done rises at edge E0+8·VECTORS, so the run takes 8·VECTORS cycles from start.
- signature updates once per RUN edge. Its value after the done edge is the final signature.

## Configuration
- ALU_BIST_FLAGS_EN defined: flags fold into MISR bits [2:0] as above.
- ALU_BIST_FLAGS_EN undefined: D = zero-extended alu_out only. Flag inputs are unused, and signature is independent of alu_zero/alu_overflow/alu_cout.

## Test plan
- Reset, then start pulse with defaults → cycle after E0: busy=1, alu_S=0, alu_A=32'h0000_0001, alu_B=32'hFFFF_FFFE. Next cycle: alu_A=32'h0000_0002, alu_B=32'hFFBF_FFFB.
- Bench ALU model, VECTORS=2, expected_sig set from a bench-computed MISR → done exactly 16 cycles after start, pass=1, alu_S visits 0,0,1,1,…,7,7.
- Same run with expected_sig XOR 1 → done=1, pass=0, signature equal to the bench value.
- Start pulsed repeatedly during RUN → no restart, done still at E0+8·VECTORS. Start in DONE → done=0 and busy=1 next cycle, alu_A=SEED again.
- Reset asserted at vector 5 → busy/done/pass/signature/alu_* = 0 immediately. A following start gives a signature identical to an uninterrupted run.
- alu_zero forced to 1 for one vector: with ALU_BIST_FLAGS_EN, final signature differs from the baseline. Without it, the signature equals the baseline.
